// File: rtl/alu_4bit_pkg.sv
// Shared definitions for the 4-bit ALU: datapath width, opcode map and
// the quotient returned on divide-by-zero.
package alu_4bit_pkg;

    localparam int DW = 4;
    localparam logic [DW-1:0] DIV_ZERO_Q = 4'hF;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_NAND = 4'b0111,
        OP_NOR  = 4'b1000,
        OP_XNOR = 4'b1001,
        OP_NOT  = 4'b1010,
        OP_SHL  = 4'b1011,
        OP_SHR  = 4'b1100,
        OP_ROL  = 4'b1101,
        OP_CMP  = 4'b1110,
        OP_INC  = 4'b1111
    } opcode_t;

endpackage

// File: rtl/alu_4bit_core.sv
// Combinational compute slice of the 4-bit ALU (operands + opcode -> y, x).
// Status flags are generated only when ALU_FLAGS_EN is defined.
module alu_4bit_core
    import alu_4bit_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  opcode_t       i_opcode,
`ifdef ALU_FLAGS_EN
    output logic [3:0]    o_flags,
`endif
    output logic [DW-1:0] o_y,
    output logic [DW-1:0] o_x
);

    logic [DW:0]     w_sum;
    logic [DW:0]     w_diff;
    logic [DW:0]     w_inc;
    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   w_quot;
    logic [DW-1:0]   w_rem;
    logic [DW-1:0]   w_rol;
    logic            w_b_zero;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc    = {1'b0, i_a} + 5'd1;
    assign w_prod   = {4'b0000, i_a} * {4'b0000, i_b};
    assign w_b_zero = (i_b == 4'd0);

    // Divide-by-zero is defined, not trapped: all-ones quotient, dividend as remainder.
    assign w_quot = w_b_zero ? DIV_ZERO_Q : (i_a / i_b);
    assign w_rem  = w_b_zero ? i_a        : (i_a % i_b);

    always_comb begin
        case (i_b[1:0])
            2'd0:    w_rol = i_a;
            2'd1:    w_rol = {i_a[2:0], i_a[3]};
            2'd2:    w_rol = {i_a[1:0], i_a[3:2]};
            default: w_rol = {i_a[0],   i_a[3:1]};
        endcase
    end

    always_comb begin
        o_y = '0;
        o_x = '0;
        case (i_opcode)
            OP_ADD:  begin o_y = w_sum[3:0];  o_x = {3'b000, w_sum[4]};  end
            OP_SUB:  begin o_y = w_diff[3:0]; o_x = {3'b000, w_diff[4]}; end
            OP_MUL:  begin o_y = w_prod[3:0]; o_x = w_prod[7:4];         end
            OP_DIV:  begin o_y = w_quot;      o_x = w_rem;               end
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XNOR: o_y = ~(i_a ^ i_b);
            OP_NOT:  begin o_y = ~i_a;              o_x = ~i_b;               end
            OP_SHL:  begin o_y = {i_a[2:0], 1'b0};  o_x = {3'b000, i_a[3]};   end
            OP_SHR:  begin o_y = {1'b0, i_a[3:1]};  o_x = {3'b000, i_a[0]};   end
            OP_ROL:  o_y = w_rol;
            OP_CMP:  o_y = {1'b0, (i_a > i_b), (i_a == i_b), (i_a < i_b)};
            OP_INC:  begin o_y = w_inc[3:0]; o_x = {3'b000, w_inc[4]}; end
            default: begin o_y = '0; o_x = '0; end
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic w_carry;
    logic w_ovf;

    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_opcode)
            // Signed overflow: result sign differs from the sign both effective operands share.
            OP_ADD: begin
                w_carry = o_x[0];
                w_ovf   = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
            end
            OP_SUB: begin
                w_carry = o_x[0];
                w_ovf   = (i_a[3] != i_b[3]) && (w_diff[3] != i_a[3]);
            end
            OP_INC: begin
                w_carry = o_x[0];
                w_ovf   = !i_a[3] && w_inc[3];
            end
            OP_SHL, OP_SHR: w_carry = o_x[0];
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
        o_flags = {(o_y == 4'd0), o_y[3], w_carry, w_ovf};
    end
`endif

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: one-cycle latency, valid-gated output registers.
// Optional status flags output enabled by defining ALU_FLAGS_EN.
module alu_4bit
    import alu_4bit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    opcode,
`ifdef ALU_FLAGS_EN
    output logic [3:0]    flags,
`endif
    output logic          out_valid,
    output logic [DW-1:0] y,
    output logic [DW-1:0] x
);

    logic [DW-1:0] w_y;
    logic [DW-1:0] w_x;
    logic [DW-1:0] r_y;
    logic [DW-1:0] r_x;
    logic          r_valid;

`ifdef ALU_FLAGS_EN
    logic [3:0] w_flags;
    logic [3:0] r_flags;
`endif

    alu_4bit_core u_core (
        .i_a      (a),
        .i_b      (b),
        .i_opcode (opcode_t'(opcode)),
`ifdef ALU_FLAGS_EN
        .o_flags  (w_flags),
`endif
        .o_y      (w_y),
        .o_x      (w_x)
    );

    // Results load only on valid input; otherwise they hold while out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_x     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_y;
                r_x <= w_x;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (in_valid) begin
            r_flags <= w_flags;
        end
    end
    assign flags = r_flags;
`endif

    assign y         = r_y;
    assign x         = r_x;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed vectors plus randomized traffic
// compared against an arithmetic reference model (flags checked with ALU_FLAGS_EN).
module tb_alu_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] opcode;
    logic       out_valid;
    logic [3:0] y;
    logic [3:0] x;
`ifdef ALU_FLAGS_EN
    logic [3:0] flags;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_y;
    logic [3:0] exp_x;
    logic [3:0] exp_f;
    logic       exp_v;

    alu_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
`ifdef ALU_FLAGS_EN
        .flags     (flags),
`endif
        .out_valid (out_valid),
        .y         (y),
        .x         (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, obs, expv);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Reference model in plain integer arithmetic: returns {flags, x, y}.
    function automatic logic [11:0] model(input int av, input int bv, input int op);
        int ry, rx, ov, sr, k, cy, z, n;
        ry = 0; rx = 0; ov = 0; sr = 0; cy = 0;
        case (op)
            0:  begin ry = (av + bv) % 16; rx = (av + bv) / 16;
                      sr = sgn(av) + sgn(bv); ov = (sr > 7 || sr < -8) ? 1 : 0; end
            1:  begin ry = (av - bv + 16) % 16; rx = (av < bv) ? 1 : 0;
                      sr = sgn(av) - sgn(bv); ov = (sr > 7 || sr < -8) ? 1 : 0; end
            2:  begin ry = (av * bv) % 16; rx = (av * bv) / 16; end
            3:  begin if (bv == 0) begin ry = 15; rx = av; end
                      else begin ry = av / bv; rx = av % bv; end end
            4:  ry = av & bv;
            5:  ry = av | bv;
            6:  ry = av ^ bv;
            7:  ry = 15 - (av & bv);
            8:  ry = 15 - (av | bv);
            9:  ry = 15 - (av ^ bv);
            10: begin ry = 15 - av; rx = 15 - bv; end
            11: begin ry = (av * 2) % 16; rx = av / 8; end
            12: begin ry = av / 2; rx = av % 2; end
            13: begin k = bv % 4; ry = (av * (1 << k)) % 16 + av / (1 << (4 - k)); end
            14: ry = ((av > bv) ? 4 : 0) + ((av == bv) ? 2 : 0) + ((av < bv) ? 1 : 0);
            default: begin ry = (av + 1) % 16; rx = (av + 1) / 16;
                      sr = sgn(av) + 1; ov = (sr > 7) ? 1 : 0; end
        endcase
        if (op == 0 || op == 1 || op == 15 || op == 11 || op == 12) cy = rx % 2;
        z = (ry == 0) ? 1 : 0;
        n = (ry >= 8) ? 1 : 0;
        return {4'(z * 8 + n * 4 + cy * 2 + ov), 4'(rx), 4'(ry)};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, {7'd0, out_valid}, {7'd0, exp_v});
        check({tag, "_y"}, {4'd0, y}, {4'd0, exp_y});
        check({tag, "_x"}, {4'd0, x}, {4'd0, exp_x});
`ifdef ALU_FLAGS_EN
        check({tag, "_flags"}, {4'd0, flags}, {4'd0, exp_f});
`endif
    endtask

    // Drive one cycle at the falling edge, sample 1 time unit after the rising edge.
    task automatic do_op(input string tag, input logic v, input logic [3:0] av,
                         input logic [3:0] bv, input logic [3:0] op);
        logic [11:0] m;
        @(negedge clk);
        in_valid = v;
        a        = av;
        b        = bv;
        opcode   = op;
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) begin
            m     = model(int'(av), int'(bv), int'(op));
            exp_y = m[3:0];
            exp_x = m[7:4];
            exp_f = m[11:8];
        end
        $display("[TB] %s v=%0b op=%b a=%b b=%b -> valid=%0b y=%b x=%b",
                 tag, v, op, av, bv, out_valid, y, x);
        check_outputs(tag);
    endtask

    logic [7:0] sweep_tbl [16];

    initial begin
        sweep_tbl = '{8'hF0, 8'h50, 8'h23, 8'h20, 8'h00, 8'hF0, 8'hF0, 8'hF0,
                      8'h00, 8'h00, 8'h5A, 8'h41, 8'h50, 8'h50, 8'h40, 8'hB0};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        opcode   = '0;
        exp_y = '0; exp_x = '0; exp_f = '0; exp_v = 1'b0;

        #3;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Opcode sweep with a=1010, b=0101 against the published table.
        for (int op = 0; op < 16; op++) begin
            do_op("sweep", 1'b1, 4'b1010, 4'b0101, 4'(op));
            check("sweep_tbl", {y, x}, sweep_tbl[op]);
        end

        do_op("add_carry", 1'b1, 4'b1111, 4'b0001, 4'b0000);
        check("add_carry_yx", {y, x}, 8'h01);
        do_op("inc_wrap", 1'b1, 4'b1111, 4'b0000, 4'b1111);
        check("inc_wrap_yx", {y, x}, 8'h01);
        do_op("sub_borrow", 1'b1, 4'b0011, 4'b0101, 4'b0001);
        check("sub_borrow_yx", {y, x}, 8'hE1);
        do_op("div_zero", 1'b1, 4'b0111, 4'b0000, 4'b0011);
        check("div_zero_yx", {y, x}, 8'hF7);
        do_op("mul_max", 1'b1, 4'b1111, 4'b1111, 4'b0010);
        check("mul_max_yx", {y, x}, 8'h1E);

        // Drop in_valid for three cycles: results hold while inputs wiggle.
        for (int i = 0; i < 3; i++)
            do_op("hold", 1'b0, 4'(i + 3), 4'(9 - i), 4'(i));
        check("hold_yx", {y, x}, 8'h1E);
        do_op("cmp_eq", 1'b1, 4'b0110, 4'b0110, 4'b1110);
        check("cmp_eq_y", {4'd0, y}, 8'h02);

`ifdef ALU_FLAGS_EN
        do_op("flag_ovf", 1'b1, 4'b0111, 4'b0001, 4'b0000);
        check("flag_ovf_f", {y, flags}, 8'h85);
        do_op("flag_zero", 1'b1, 4'b1010, 4'b0101, 4'b0100);
        check("flag_zero_z", {7'd0, flags[3]}, 8'h01);
`endif

        // Asynchronous reset mid-stream, between clock edges.
        do_op("pre_rst", 1'b1, 4'b1010, 4'b0101, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        exp_y = '0; exp_x = '0; exp_f = '0; exp_v = 1'b0;
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 1'b1, 4'b0011, 4'b0010, 4'b0010);

        // Randomized traffic with random valid gaps.
        for (int i = 0; i < 300; i++)
            do_op("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
